vliw_wb_arbiter: RTL and testbench

VLIW_WB_ARBITER -- requirements
Module: vliw_wb_arbiter

---
 rtl/cvw_pkg.sv | 8 +
 rtl/vliw_wb_arbiter_pkg.sv | 14 +
 rtl/vliw_wb_arbiter_prienc.sv | 30 +++
 rtl/vliw_wb_arbiter.sv | 100 ++++++++++
 tb/tb_vliw_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cvw_pkg.sv
// Core configuration record; the arbiter only needs XLEN from it.
package cvw;
  typedef struct packed {
    logic [31:0] XLEN;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 32'd32};
endpackage

// File: rtl/vliw_wb_arbiter_pkg.sv
// Shared VLIW writeback definitions: bundle geometry defaults and drain FSM states.
package vliw_wb_arbiter_pkg;
  localparam int NLANES_DEF  = 4;
  localparam int NWPORTS_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vliw_wb_arbiter_prienc.sv
// Picks the lowest NWPORTS set request bits and reports, per port, which lane it carries.
module wb_lane_prienc #(
  parameter int NLANES  = 4,
  parameter int NWPORTS = 2,
  parameter int IW      = 2
) (
  input  logic [NLANES-1:0]     req,
  output logic [NLANES-1:0]     grant,
  output logic [NWPORTS-1:0]    port_vld,
  output logic [NWPORTS*IW-1:0] port_idx
);
  int cnt;

  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_idx = '0;
    cnt      = 0;
    for (int i = 0; i < NLANES; i++) begin
      for (int k = 0; k < NWPORTS; k++) begin
        if (req[i] && cnt == k) begin
          grant[i]               = 1'b1;
          port_vld[k]            = 1'b1;
          port_idx[k*IW +: IW]   = IW'(i);
        end
      end
      if (req[i] && cnt < NWPORTS) cnt = cnt + 1;
    end
  end
endmodule

// File: rtl/vliw_wb_arbiter.sv
// Shares NWPORTS regfile write ports among NLANES writeback lanes, zero added latency;
// when a bundle has more effective writes than ports it requests StallW and drains over extra cycles.
module vliw_wb_arbiter
  import vliw_wb_arbiter_pkg::*;
#(
  parameter cvw::cvw_t P       = cvw::CVW_DEFAULT,
  parameter int        NLANES  = NLANES_DEF,
  parameter int        NWPORTS = NWPORTS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      FlushW,
  input  logic [NLANES-1:0]         LaneWeW,
  input  logic [NLANES*5-1:0]       LaneRdW,
  input  logic [NLANES*P.XLEN-1:0]  LaneWdW,
  output logic [NWPORTS-1:0]        PortWe,
  output logic [NWPORTS*5-1:0]      PortA,
  output logic [NWPORTS*P.XLEN-1:0] PortWd,
  output logic                      WbStallReq,
  output logic [NLANES-1:0]         LaneDoneW
);
  localparam int XLEN = int'(P.XLEN);
  localparam int IW   = idx_w(NLANES);

  logic [4:0]      rd [NLANES];
  logic [XLEN-1:0] wd [NLANES];
  logic [NLANES-1:0] rd_nz, killed, eligible, grant, remaining;
  logic [NLANES-1:0] served_q, served_d;
  logic [NWPORTS-1:0] port_vld;
  logic [NWPORTS*IW-1:0] port_idx;
  logic active;
  wb_state_e state_q, state_d;

  for (genvar g = 0; g < NLANES; g++) begin : g_unpack
    assign rd[g]    = LaneRdW[g*5 +: 5];
    assign wd[g]    = LaneWdW[g*XLEN +: XLEN];
    assign rd_nz[g] = |rd[g];
  end

  // A later lane writing the same rd supersedes every earlier one in the bundle.
  always_comb begin
    killed = '0;
    for (int i = 0; i < NLANES; i++) begin
      for (int j = i + 1; j < NLANES; j++) begin
        if (LaneWeW[j] && rd_nz[i] && rd[j] == rd[i]) killed[i] = 1'b1;
      end
    end
  end

  assign eligible = LaneWeW & rd_nz & ~killed & ~served_q;

  wb_lane_prienc #(
    .NLANES (NLANES),
    .NWPORTS(NWPORTS),
    .IW     (IW)
  ) u_prienc (
    .req     (eligible),
    .grant   (grant),
    .port_vld(port_vld),
    .port_idx(port_idx)
  );

  assign active     = ~reset & ~FlushW;
  assign remaining  = eligible & ~grant;
  assign WbStallReq = active & (|remaining);
  assign LaneDoneW  = reset ? '1 : (served_q | grant | killed | ~LaneWeW | ~rd_nz);

  always_comb begin
    PortWe = '0;
    PortA  = '0;
    PortWd = '0;
    for (int k = 0; k < NWPORTS; k++) begin
      if (active && port_vld[k]) begin
        PortWe[k]              = 1'b1;
        PortA[k*5 +: 5]        = rd[port_idx[k*IW +: IW]];
        PortWd[k*XLEN +: XLEN] = wd[port_idx[k*IW +: IW]];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    served_d = WbStallReq ? (served_q | grant) : '0;
    case (state_q)
      IDLE:    if (WbStallReq) state_d = DRAIN;
      DRAIN:   if (!WbStallReq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
    end
  end
endmodule

// File: tb/tb_vliw_wb_arbiter.sv
// Bench: directed bundles plus random bundles against a bundle-level writeback model.
module tb_vliw_wb_arbiter;
  localparam int NL = 4;
  localparam int NW = 2;
  localparam int XL = 32;

  logic clk;
  logic reset;
  logic FlushW;
  logic [NL-1:0]    LaneWeW;
  logic [NL*5-1:0]  LaneRdW;
  logic [NL*XL-1:0] LaneWdW;
  logic [NW-1:0]    PortWe;
  logic [NW*5-1:0]  PortA;
  logic [NW*XL-1:0] PortWd;
  logic             WbStallReq;
  logic [NL-1:0]    LaneDoneW;

  vliw_wb_arbiter #(.NLANES(NL), .NWPORTS(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .FlushW    (FlushW),
    .LaneWeW   (LaneWeW),
    .LaneRdW   (LaneRdW),
    .LaneWdW   (LaneWdW),
    .PortWe    (PortWe),
    .PortA     (PortA),
    .PortWd    (PortWd),
    .WbStallReq(WbStallReq),
    .LaneDoneW (LaneDoneW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int c       = 0;
  bit hold    = 1'b0;
  bit chk_en  = 1'b0;

  logic [NW-1:0]    exp_pwe;
  logic [NW*5-1:0]  exp_pa;
  logic [NW*XL-1:0] exp_pwd;
  logic             exp_stall;
  logic [NL-1:0]    exp_done;

  logic [XL-1:0] rf_model [32];
  logic [XL-1:0] rf_dut   [32];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] lrd(input int i);
    return LaneRdW[i*5 +: 5];
  endfunction

  function automatic logic [XL-1:0] lwd(input int i);
    return LaneWdW[i*XL +: XL];
  endfunction

  // Bundle view: effective writes are the last writer of each non-zero rd, kept in lane order;
  // cycle c of the bundle commits entries c*NW .. c*NW+NW-1 of that list.
  task automatic model_eval();
    int eff[$];
    int pos[NL];
    bit ok;
    int idx;
    exp_pwe   = '0;
    exp_pa    = '0;
    exp_pwd   = '0;
    exp_stall = 1'b0;
    exp_done  = '1;
    if (reset) return;
    for (int i = 0; i < NL; i++) begin
      pos[i] = -1;
      if (LaneWeW[i] && lrd(i) != 5'd0) begin
        ok = 1'b1;
        for (int j = i + 1; j < NL; j++)
          if (LaneWeW[j] && lrd(j) == lrd(i)) ok = 1'b0;
        if (ok) begin
          pos[i] = eff.size();
          eff.push_back(i);
        end
      end
    end
    for (int i = 0; i < NL; i++)
      exp_done[i] = (pos[i] < 0) || (pos[i] < (c + 1) * NW);
    if (FlushW) return;
    for (int k = 0; k < NW; k++) begin
      idx = c * NW + k;
      if (idx < eff.size()) begin
        exp_pwe[k]          = 1'b1;
        exp_pa[k*5 +: 5]    = lrd(eff[idx]);
        exp_pwd[k*XL +: XL] = lwd(eff[idx]);
      end
    end
    exp_stall = (eff.size() > (c + 1) * NW);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("port_we", 128'(PortWe), 128'(exp_pwe));
      chk("port_a", 128'(PortA), 128'(exp_pa));
      chk("port_wd", 128'(PortWd), 128'(exp_pwd));
      chk("stall", 128'(WbStallReq), 128'(exp_stall));
      chk("lane_done", 128'(LaneDoneW), 128'(exp_done));
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NW; k++)
      if (PortWe[k]) rf_dut[PortA[k*5 +: 5]] <= PortWd[k*XL +: XL];
  end

  task automatic step();
    model_eval();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    if (!reset && !FlushW) begin
      for (int k = 0; k < NW; k++)
        if (exp_pwe[k]) rf_model[exp_pa[k*5 +: 5]] = exp_pwd[k*XL +: XL];
    end
    if (!reset && !FlushW && exp_stall) c++;
    else c = 0;
    hold = exp_stall;
    #1;
  endtask

  task automatic clear_lanes();
    LaneWeW = '0;
    LaneRdW = '0;
    LaneWdW = '0;
  endtask

  task automatic set_lane(input int i, input logic [4:0] rd, input logic [XL-1:0] wd);
    LaneWeW[i]         = 1'b1;
    LaneRdW[i*5 +: 5]  = rd;
    LaneWdW[i*XL +: XL] = wd;
  endtask

  // Checks the DUT and the model against the same hand-derived value.
  task automatic lit(input string name, input logic [127:0] dut_v, input logic [127:0] mdl_v,
                     input logic [127:0] exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  task automatic bundle_x1_x4();
    clear_lanes();
    for (int i = 0; i < NL; i++) set_lane(i, 5'(i + 1), XL'(i + 1));
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      rf_dut[i]   = '0;
    end
    reset  = 1'b1;
    FlushW = 1'b0;
    clear_lanes();
    @(posedge clk);
    #1;

    // Reset holds outputs quiet even with a live bundle on the inputs.
    bundle_x1_x4();
    step();
    lit("rst_we", PortWe, exp_pwe, 0);
    lit("rst_stall", WbStallReq, exp_stall, 0);
    lit("rst_done", LaneDoneW, exp_done, 4'hF);
    lit("rst_a", PortA, exp_pa, 0);
    adv();
    reset = 1'b0;

    clear_lanes();
    step();
    lit("idle_we", PortWe, exp_pwe, 0);
    lit("idle_stall", WbStallReq, exp_stall, 0);
    adv();

    clear_lanes();
    set_lane(0, 5'd5, 32'hA);
    set_lane(1, 5'd6, 32'hB);
    step();
    lit("two_we", PortWe, exp_pwe, 2'b11);
    lit("two_a", PortA, exp_pa, {5'd6, 5'd5});
    lit("two_wd", PortWd, exp_pwd, {32'hB, 32'hA});
    lit("two_stall", WbStallReq, exp_stall, 0);
    adv();

    bundle_x1_x4();
    step();
    lit("four_c1_a", PortA, exp_pa, {5'd2, 5'd1});
    lit("four_c1_stall", WbStallReq, exp_stall, 1);
    lit("four_c1_done", LaneDoneW, exp_done, 4'b0011);
    adv();
    step();
    lit("four_c2_a", PortA, exp_pa, {5'd4, 5'd3});
    lit("four_c2_wd", PortWd, exp_pwd, {32'd4, 32'd3});
    lit("four_c2_stall", WbStallReq, exp_stall, 0);
    lit("four_c2_done", LaneDoneW, exp_done, 4'hF);
    adv();

    clear_lanes();
    set_lane(0, 5'd7, 32'h11);
    set_lane(1, 5'd0, 32'h99);
    set_lane(2, 5'd7, 32'h22);
    step();
    lit("kill_we", PortWe, exp_pwe, 2'b01);
    lit("kill_a", PortA, exp_pa, 10'd7);
    lit("kill_wd", PortWd, exp_pwd, 64'h22);
    lit("kill_stall", WbStallReq, exp_stall, 0);
    lit("kill_done", LaneDoneW, exp_done, 4'hF);
    adv();

    clear_lanes();
    set_lane(0, 5'd8, 32'h80);
    set_lane(1, 5'd9, 32'h90);
    set_lane(2, 5'd10, 32'hA0);
    step();
    lit("flush_c1_stall", WbStallReq, exp_stall, 1);
    adv();
    FlushW = 1'b1;
    step();
    lit("flush_c2_we", PortWe, exp_pwe, 0);
    lit("flush_c2_stall", WbStallReq, exp_stall, 0);
    adv();
    FlushW = 1'b0;
    step();
    lit("flush_c3_we", PortWe, exp_pwe, 2'b11);
    lit("flush_c3_a", PortA, exp_pa, {5'd9, 5'd8});
    lit("flush_c3_stall", WbStallReq, exp_stall, 1);
    adv();
    step();
    lit("flush_c4_a", PortA, exp_pa, 10'd10);
    lit("flush_c4_stall", WbStallReq, exp_stall, 0);
    adv();

    bundle_x1_x4();
    step();
    adv();
    reset = 1'b1;
    step();
    lit("rmid_we", PortWe, exp_pwe, 0);
    lit("rmid_wd", PortWd, exp_pwd, 0);
    lit("rmid_done", LaneDoneW, exp_done, 4'hF);
    adv();
    reset = 1'b0;
    step();
    lit("rmid_next_a", PortA, exp_pa, {5'd2, 5'd1});
    lit("rmid_next_stall", WbStallReq, exp_stall, 1);
    adv();
    step();
    adv();

    for (int n = 0; n < 10000; n++) begin
      if (!hold) begin
        r = $urandom;
        LaneWeW = r[NL-1:0];
        for (int i = 0; i < NL; i++) begin
          LaneRdW[i*5 +: 5]   = 5'($urandom_range(0, 7));
          LaneWdW[i*XL +: XL] = $urandom;
        end
      end
      FlushW = ($urandom_range(0, 15) == 0);
      reset  = ($urandom_range(0, 63) == 0);
      step();
      adv();
    end
    reset  = 1'b0;
    FlushW = 1'b0;
    chk_en = 1'b0;

    for (int i = 0; i < 32; i++) chk($sformatf("regfile_x%0d", i), 128'(rf_dut[i]), 128'(rf_model[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
